// File: rtl/serial_add_if.sv
// ---------------------------------------------------------------------------
// serial_add_if
// Request/response bundle for the bit-serial add controller.
//   start        request strobe, accepted only while ready=1
//   a, b, cin    operands and carry-in, sampled on the accepting edge
//   sub          (only with SERIAL_ADD_SUB_EN) 1 = subtract a - b
//   ready        controller idle, a start will be accepted
//   done         one-cycle pulse, sum/cout just updated
//   sum, cout    registered result, held until the next done
// Modports: master drives requests, slave is the controller.
// Optional feature macro: SERIAL_ADD_SUB_EN
// ---------------------------------------------------------------------------
interface serial_add_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    input  ready, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    output ready, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder: one full-adder cell (udp_sum/udp_cy) is reused over
// WIDTH clocks, LSB first, with the inter-bit carry held in a flip-flop.
// Produces {cout,sum} = a + b + cin and a one-clock done pulse.
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous, active-high reset
//   bus   serial_add_if.slave (start/a/b/cin[/sub] in, ready/done/sum/cout out)
// Parameters:
//   WIDTH operand/result width, 2..32
// Optional feature macro: SERIAL_ADD_SUB_EN
//   adds bus.sub; sub=1 computes a - b (b inverted, carry forced to 1),
//   cout=1 then means no borrow. Timing is identical in both builds.
// Latency: accept at edge k, done rises at edge k+WIDTH, ready at k+WIDTH+1.
// ---------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  serial_add_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    count;
  logic             carry;
  logic             ready_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  // The single full-adder cell shared by every bit position.
  logic udp_sum;
  logic udp_cy;
  assign udp_sum = shift_a[0] ^ shift_b[0] ^ carry;
  assign udp_cy  = (shift_a[0] & shift_b[0]) | (shift_a[0] & carry) |
                   (shift_b[0] & carry);

  // Operand B and initial carry as loaded on the accepting edge.
  logic [WIDTH-1:0] load_b;
  logic             load_carry;
`ifdef SERIAL_ADD_SUB_EN
  // a - b = a + ~b + 1; cin is ignored when subtracting.
  assign load_b     = bus.sub ? ~bus.b : bus.b;
  assign load_carry = bus.sub ? 1'b1   : bus.cin;
`else
  assign load_b     = bus.b;
  assign load_carry = bus.cin;
`endif

  // NOTE: every register in this block uses non-blocking assignment so all
  // state updates see the pre-edge values, exactly like the hardware does.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too (not just the FSM) so the
      // held sum/cout outputs are defined and an aborted run leaves no trace.
      state   <= IDLE;
      shift_a <= '0;
      shift_b <= '0;
      res     <= '0;
      count   <= '0;
      carry   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            shift_a <= bus.a;
            shift_b <= load_b;
            carry   <= load_carry;
            count   <= '0;
            res     <= '0;
            ready_q <= 1'b0;
            state   <= RUN;
          end
        end

        RUN: begin
          shift_a <= {1'b0, shift_a[WIDTH-1:1]};
          shift_b <= {1'b0, shift_b[WIDTH-1:1]};
          carry   <= udp_cy;
          // Result fills from the top; after WIDTH shifts bit 0 lands at LSB.
          res     <= {udp_sum, res[WIDTH-1:1]};
          if (count == LAST) begin
            sum_q  <= {udp_sum, res[WIDTH-1:1]};
            cout_q <= udp_cy;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end

        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;

endmodule
